data_memory_responder: RTL and testbench

Responder end of the CPU's memory-access-stage data interface. Accepts RV32IM load/store requests from the memory-access stage, holds the pipeline with `BUSY` for a fixed access latency, then performs byte/half/word stores or sign/zero-extended loads against an internal word-organised RAM. Sits beside the `CPU` top level as the data memory, in the opposite role to the memory-access stage that initiates requests.

---
 rtl/data_memory_responder.sv | 199 +++++++++++++++++++
 tb/tb_data_memory_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory responder with fixed access latency and RV32 load/store formatting

module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY,
  output logic        MEM_FAULT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // WAIT counts down to zero; the first wait cycle already holds LATENCY-2
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         SINGLE   = (LATENCY == 1);

  logic [1:0]              state;
  logic [3:0]              count;
  logic [ADDR_WIDTH+1:0]   req_addr;
  logic [2:0]              req_funct3;
  logic [31:0]             req_wdata;
  logic                    req_write;

  logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];

  logic                    request;
  logic                    illegal;
  logic                    misaligned;
  logic                    new_fault;
  logic [ADDR_WIDTH+1:0]   acc_addr;
  logic [2:0]              acc_funct3;
  logic [31:0]             acc_wdata;
  logic                    acc_write;
  logic                    commit;
  logic [1:0]              lane;
  logic [3:0]              byte_en;
  logic [31:0]             store_word;
  logic [31:0]             ram_word;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [31:0]             load_value;
  logic                    unused_addr_bits;

  // Upper address bits wrap and are intentionally ignored
  assign unused_addr_bits = ^ADDRESS[31:ADDR_WIDTH+2];

  assign request = MEM_READ | MEM_WRITE;
  assign BUSY    = ((state == S_IDLE) && request) || (state == S_WAIT);

  // Classify the request presented in IDLE as legal or faulting
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (MEM_WRITE) begin
      illegal = FUNCT3[2] | (FUNCT3[1:0] == 2'b11);
    end else begin
      illegal = (FUNCT3 == 3'b011) || (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
    end
    if (FUNCT3[1:0] == 2'b01 && ADDRESS[0]) begin
      misaligned = 1'b1;
    end
    if (FUNCT3[1:0] == 2'b10 && ADDRESS[1:0] != 2'b00) begin
      misaligned = 1'b1;
    end
    new_fault = illegal | misaligned;
  end

  // Single-cycle latency commits straight from the live inputs; otherwise the latched request
  always_comb begin
    if (state == S_IDLE) begin
      acc_addr   = ADDRESS[ADDR_WIDTH+1:0];
      acc_funct3 = FUNCT3;
      acc_wdata  = WRITE_DATA;
      acc_write  = MEM_WRITE;
    end else begin
      acc_addr   = req_addr;
      acc_funct3 = req_funct3;
      acc_wdata  = req_wdata;
      acc_write  = req_write;
    end
    commit = !RESET &&
             ((SINGLE && state == S_IDLE && request && !new_fault) ||
              (state == S_WAIT && count == 4'd0));
  end

  // Store lane enables and lane-replicated store data
  always_comb begin
    lane       = acc_addr[1:0];
    byte_en    = 4'b0000;
    store_word = acc_wdata;
    case (acc_funct3)
      3'b000: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        byte_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
        store_word = {2{acc_wdata[15:0]}};
      end
      3'b010: begin
        byte_en    = 4'b1111;
        store_word = acc_wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = acc_wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    ram_word   = ram[acc_addr[ADDR_WIDTH+1:2]];
    load_byte  = ram_word[8*lane +: 8];
    load_half  = acc_addr[1] ? ram_word[31:16] : ram_word[15:0];
    case (acc_funct3)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = ram_word;
    endcase
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge CLK) begin
    if (commit && acc_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[acc_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  // Request FSM, latched request, load capture and fault flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      req_addr   <= '0;
      req_funct3 <= 3'd0;
      req_wdata  <= 32'd0;
      req_write  <= 1'b0;
      READ_DATA  <= 32'd0;
      MEM_FAULT  <= 1'b0;
    end else begin
      if (commit && !acc_write) begin
        READ_DATA <= load_value;
      end
      case (state)
        S_IDLE: begin
          MEM_FAULT <= 1'b0;
          if (request) begin
            req_addr   <= ADDRESS[ADDR_WIDTH+1:0];
            req_funct3 <= FUNCT3;
            req_wdata  <= WRITE_DATA;
            req_write  <= MEM_WRITE;
            if (new_fault) begin
              state     <= S_DONE;
              MEM_FAULT <= 1'b1;
            end else if (SINGLE) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              count <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state <= S_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          MEM_FAULT <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          MEM_FAULT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder at latencies 2, 1 and 4

module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read   [3];
  logic        mem_write  [3];
  logic [2:0]  funct3     [3];
  logic [31:0] address    [3];
  logic [31:0] write_data [3];
  logic [31:0] read_data  [3];
  logic        busy       [3];
  logic        mem_fault  [3];

  always #5 clk = ~clk;

  // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 4
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .ADDR_WIDTH(10),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) dut (
      .CLK(clk),
      .RESET(reset),
      .MEM_READ(mem_read[g]),
      .MEM_WRITE(mem_write[g]),
      .FUNCT3(funct3[g]),
      .ADDRESS(address[g]),
      .WRITE_DATA(write_data[g]),
      .READ_DATA(read_data[g]),
      .BUSY(busy[g]),
      .MEM_FAULT(mem_fault[g])
    );
  end

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          busy_w;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  logic [31:0] cur_rd [3];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input int k, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input string tag, output int t_start, output int t_done);
    exp_t        e;
    int          key;
    int          ln;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    bit          flt;
    bit          done;
    int          nb;
    key = k * 4096 + int'(addr[11:2]);
    ln  = int'(addr[1:0]);
    if (wr) flt = (f3 != 3'd0) && (f3 != 3'd1) && (f3 != 3'd2);
    else    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) flt = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'd0) flt = 1'b1;
    w = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
    if (!flt) begin
      if (wr) begin
        if (f3 == 3'd0) w[8*ln +: 8] = wd[7:0];
        else if (f3 == 3'd1) w[16*(ln/2) +: 16] = wd[15:0];
        else w = wd;
        mdl[key] = w;
      end else begin
        b = w[8*ln +: 8];
        h = w[16*(ln/2) +: 16];
        case (f3)
          3'd0:    cur_rd[k] = {{24{b[7]}}, b};
          3'd1:    cur_rd[k] = {{16{h[15]}}, h};
          3'd4:    cur_rd[k] = {24'd0, b};
          3'd5:    cur_rd[k] = {16'd0, h};
          default: cur_rd[k] = w;
        endcase
      end
    end
    e.data   = cur_rd[k];
    e.fault  = flt;
    e.busy_w = flt ? 1 : lat_of(k);
    sb.push_back(e);

    @(negedge clk);
    mem_read[k]   = !wr;
    mem_write[k]  = wr;
    funct3[k]     = f3;
    address[k]    = addr;
    write_data[k] = wd;
    t_start = cyc;
    nb   = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!busy[k]) done = 1'b1;
      else begin
        nb++;
        @(negedge clk);
      end
    end
    t_done = cyc;
    e = sb.pop_front();
    check({tag, " done_reached"}, 32'(done), 32'd1);
    check({tag, " busy_width"}, 32'(nb), 32'(e.busy_w));
    check({tag, " read_data"}, read_data[k], e.data);
    check({tag, " mem_fault"}, 32'(mem_fault[k]), 32'(e.fault));
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
  endtask

  initial begin
    int s1, d1, s2, d2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_read[k]   = 1'b0;
      mem_write[k]  = 1'b0;
      funct3[k]     = 3'd0;
      address[k]    = 32'd0;
      write_data[k] = 32'd0;
      cur_rd[k]     = 32'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset busy%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("reset read_data%0d", k), read_data[k], 32'd0);
      check($sformatf("reset mem_fault%0d", k), 32'(mem_fault[k]), 32'd0);
    end
    reset = 1'b0;

    // Basic word store/load, then byte merge and byte loads
    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10", s1, d1);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw_10", s1, d1);
    access(0, 1, 3'd0, 32'h11, 32'h0000007F, "sb_11", s1, d1);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw_10_merged", s1, d1);
    access(0, 0, 3'd0, 32'h13, 32'h0, "lb_13", s1, d1);
    access(0, 0, 3'd4, 32'h13, 32'h0, "lbu_13", s1, d1);

    // Halfword store into upper half, sign/zero-extended loads
    access(0, 1, 3'd2, 32'h20, 32'h11112222, "sw_20", s1, d1);
    access(0, 1, 3'd1, 32'h22, 32'h00008001, "sh_22", s1, d1);
    access(0, 0, 3'd1, 32'h22, 32'h0, "lh_22", s1, d1);
    access(0, 0, 3'd5, 32'h22, 32'h0, "lhu_22", s1, d1);
    access(0, 0, 3'd2, 32'h20, 32'h0, "lw_20", s1, d1);
    access(0, 0, 3'd2, 32'h1010, 32'h0, "lw_wrap_10", s1, d1);

    // Faults: misaligned load, misaligned store, illegal codes
    access(0, 0, 3'd2, 32'h12, 32'h0, "lw_12_fault", s1, d1);
    @(negedge clk);
    #1;
    check("fault_clears", 32'(mem_fault[0]), 32'd0);
    access(0, 1, 3'd2, 32'h30, 32'h55555555, "sw_30", s1, d1);
    access(0, 1, 3'd1, 32'h31, 32'h0000AAAA, "sh_31_fault", s1, d1);
    access(0, 1, 3'd3, 32'h30, 32'hFFFFFFFF, "st_f3_011_fault", s1, d1);
    access(0, 0, 3'd2, 32'h30, 32'h0, "lw_30_old", s1, d1);
    access(0, 0, 3'd7, 32'h30, 32'h0, "ld_f3_111_fault", s1, d1);

    // Latency 1 and 4: busy width and back-to-back throughput
    for (int k = 1; k < 3; k++) begin
      access(k, 1, 3'd2, 32'h10, 32'hA5A5_0000 + 32'(k), $sformatf("sw_lat%0d", lat_of(k)), s1, d1);
      access(k, 0, 3'd2, 32'h10, 32'h0, $sformatf("lw1_lat%0d", lat_of(k)), s1, d1);
      access(k, 0, 3'd0, 32'h10, 32'h0, $sformatf("lb2_lat%0d", lat_of(k)), s2, d2);
      check($sformatf("b2b_cycles_lat%0d", lat_of(k)), 32'(d2 - s1 + 1), 32'(2 * (lat_of(k) + 1)));
      access(k, 0, 3'd1, 32'h11, 32'h0, $sformatf("lh_fault_lat%0d", lat_of(k)), s1, d1);
    end

    // Reset during WAIT of a store discards it and clears outputs
    access(0, 1, 3'd2, 32'h40, 32'hCAFEF00D, "sw_40", s1, d1);
    access(0, 0, 3'd2, 32'h40, 32'h0, "lw_40", s1, d1);
    @(negedge clk);
    mem_write[0]  = 1'b1;
    funct3[0]     = 3'd2;
    address[0]    = 32'h40;
    write_data[0] = 32'h12345678;
    @(negedge clk);
    #1;
    check("mid_store_busy", 32'(busy[0]), 32'd1);
    reset        = 1'b1;
    mem_write[0] = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_busy", 32'(busy[0]), 32'd0);
    check("post_reset_read_data", read_data[0], 32'd0);
    check("post_reset_mem_fault", 32'(mem_fault[0]), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cur_rd[k] = 32'd0;
    access(0, 0, 3'd2, 32'h40, 32'h0, "lw_40_after_reset", s1, d1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
